// File: rtl/fixed_point_7seg_seq_if.sv
// Handshake/bus bundle between the ALU result register, the converter and the display drivers.
// Latency: none, wires only.
// Backpressure: none; start is a request pulse, done is a one-cycle completion pulse.
// Ports: master drives start/data_in and observes status and segments; slave is the converter side.
interface fixed_point_7seg_seq_if #(
  parameter int WIDTH       = 16,
  parameter int INT_DIGITS  = 3,
  parameter int FRAC_DIGITS = 2
);
  logic                     start;
  logic [WIDTH-1:0]         data_in;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic [6:0]               seg_sign;
  logic [7*INT_DIGITS-1:0]  seg_int;
  logic [7*FRAC_DIGITS-1:0] seg_frac;

  modport master (
    output start, data_in,
    input  busy, done, overflow, seg_sign, seg_int, seg_frac
  );

  modport slave (
    input  start, data_in,
    output busy, done, overflow, seg_sign, seg_int, seg_frac
  );
endinterface

// File: rtl/fixed_point_7seg_seq.sv
// Signed fixed-point to active-low gfedcba 7-segment converter (double-dabble integer, x10 fraction).
// Latency: done pulses WIDTH-FRAC_BITS+FRAC_DIGITS+1 cycles after the edge that accepts start.
// Backpressure: start accepted only in IDLE or on the done cycle; start while busy is dropped.
// Ports: clk, rst (async, active-high); bus (slave): start, data_in, busy, done, overflow,
//        seg_sign, seg_int (MSD in top 7 bits), seg_frac (tenths in top 7 bits).
// Build option: define LEADING_ZERO_BLANK_EN to blank integer digits above the leading nonzero digit.
module fixed_point_7seg_seq #(
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 6,
  parameter int INT_DIGITS  = 3,
  parameter int FRAC_DIGITS = 2
) (
  input logic                   clk,
  input logic                   rst,
  fixed_point_7seg_seq_if.slave bus
);
  localparam int          N_INT     = WIDTH - FRAC_BITS;
  localparam int          CNT_MAX   = (N_INT > FRAC_DIGITS) ? N_INT : FRAC_DIGITS;
  localparam int          CW        = $clog2(CNT_MAX + 1);
  localparam logic [31:0] INT_MAX   = 32'(10 ** INT_DIGITS - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC, S_OUT} state_t;

  state_t                   state, state_nxt;
  logic                     accept;
  logic [CW-1:0]            cnt;
  logic                     sign_q, ovf_q;
  logic [N_INT-1:0]         int_sh;
  logic [4*INT_DIGITS-1:0]  bcd;
  logic [FRAC_BITS+3:0]     f;
  logic [4*FRAC_DIGITS-1:0] fbcd;

  logic                     ovf_o;
  logic [6:0]               seg_sign_o;
  logic [7*INT_DIGITS-1:0]  seg_int_o;
  logic [7*FRAC_DIGITS-1:0] seg_frac_o;

  logic [WIDTH-1:0]         mag;
  logic [4*INT_DIGITS-1:0]  bcd_adj;
  logic [FRAC_BITS+3:0]     f_x10;
  logic [3:0]               digit;
  logic [7*INT_DIGITS-1:0]  seg_int_nxt;
  logic [7*FRAC_DIGITS-1:0] seg_frac_nxt;
`ifdef LEADING_ZERO_BLANK_EN
  logic                     lead;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Unsigned WIDTH-bit negation keeps the most negative input exact (0x8000 -> 0x8000).
  always_comb begin
    mag = bus.data_in[WIDTH-1] ? (~bus.data_in + WIDTH'(1)) : bus.data_in;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    // f holds only FRAC_BITS significant bits, so f*10 cannot overflow FRAC_BITS+4 bits.
    f_x10 = (f << 3) + (f << 1);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = S_INT;
      end
      S_INT:  if (cnt == CW'(N_INT - 1)) state_nxt = S_FRAC;
      // FRAC spends FRAC_DIGITS cycles extracting digits plus one cycle loading the display.
      S_FRAC: if (cnt == CW'(FRAC_DIGITS)) state_nxt = S_OUT;
      S_OUT:  if (bus.start) begin
        accept    = 1'b1;
        state_nxt = S_INT;
      end else begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Display formatting from the finished BCD registers.
  always_comb begin
    digit       = 4'd0;
    seg_int_nxt = '1;
`ifdef LEADING_ZERO_BLANK_EN
    lead        = 1'b1;
`endif
    for (int i = INT_DIGITS - 1; i >= 0; i--) begin
      digit = bcd[4*i +: 4];
      if (ovf_q) seg_int_nxt[7*i +: 7] = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
      else if (lead && (digit == 4'd0) && (i != 0)) seg_int_nxt[7*i +: 7] = SEG_BLANK;
      else begin
        seg_int_nxt[7*i +: 7] = seg7(digit);
        lead                  = 1'b0;
      end
`else
      else seg_int_nxt[7*i +: 7] = seg7(digit);
`endif
    end
    seg_frac_nxt = '1;
    for (int j = 0; j < FRAC_DIGITS; j++) begin
      seg_frac_nxt[7*j +: 7] = seg7(fbcd[4*j +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      int_sh     <= '0;
      bcd        <= '0;
      f          <= '0;
      fbcd       <= '0;
      ovf_o      <= 1'b0;
      seg_sign_o <= SEG_BLANK;
      seg_int_o  <= '1;
      seg_frac_o <= '1;
    end else if (accept) begin
      cnt    <= '0;
      sign_q <= bus.data_in[WIDTH-1];
      ovf_q  <= (32'(mag[WIDTH-1:FRAC_BITS]) > INT_MAX);
      int_sh <= mag[WIDTH-1:FRAC_BITS];
      f      <= {4'd0, mag[FRAC_BITS-1:0]};
      bcd    <= '0;
      fbcd   <= '0;
    end else begin
      case (state)
        S_INT: begin
          // Bits pushed out of the top nibble are dropped; overflow already flags that case.
          bcd    <= {bcd_adj[4*INT_DIGITS-2:0], int_sh[N_INT-1]};
          int_sh <= int_sh << 1;
          cnt    <= (cnt == CW'(N_INT - 1)) ? '0 : cnt + CW'(1);
        end
        S_FRAC: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(FRAC_DIGITS)) begin
            ovf_o      <= ovf_q;
            seg_sign_o <= sign_q ? SEG_DASH : SEG_BLANK;
            seg_int_o  <= seg_int_nxt;
            seg_frac_o <= seg_frac_nxt;
          end else begin
            fbcd <= (fbcd << 4) | (4*FRAC_DIGITS)'(f_x10[FRAC_BITS+3:FRAC_BITS]);
            f    <= {4'd0, f_x10[FRAC_BITS-1:0]};
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.busy     = (state == S_INT) || (state == S_FRAC);
  assign bus.done     = (state == S_OUT);
  assign bus.overflow = ovf_o;
  assign bus.seg_sign = seg_sign_o;
  assign bus.seg_int  = seg_int_o;
  assign bus.seg_frac = seg_frac_o;
endmodule

// File: tb/tb_fixed_point_7seg_seq.sv
// Bench for fixed_point_7seg_seq: directed vectors, expected displays queued at issue time,
// a negedge monitor pops and compares on every done pulse.
module tb_fixed_point_7seg_seq;
  localparam int LAT = 13;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam int BL = 10;  // blank
  localparam int DS = 11;  // dash
  localparam int Z  = 12;  // leading zero: blank in the blanking build, '0' otherwise

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   dn0 = 0;
  int   dn1 = 0;

  typedef struct {
    logic        ovf;
    logic [6:0]  sg;
    logic [20:0] si;
    logic [13:0] sf;
    int          dc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last0;
  exp_t last1;

  fixed_point_7seg_seq_if #(.WIDTH(16), .INT_DIGITS(3), .FRAC_DIGITS(2)) if0 ();
  fixed_point_7seg_seq_if #(.WIDTH(16), .INT_DIGITS(2), .FRAC_DIGITS(2)) if1 ();

  fixed_point_7seg_seq #(.WIDTH(16), .FRAC_BITS(6), .INT_DIGITS(3), .FRAC_DIGITS(2)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  fixed_point_7seg_seq #(.WIDTH(16), .FRAC_BITS(6), .INT_DIGITS(2), .FRAC_DIGITS(2)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'b1000000;  1: enc = 7'b1111001;  2: enc = 7'b0100100;
      3: enc = 7'b0110000;  4: enc = 7'b0011001;  5: enc = 7'b0010010;
      6: enc = 7'b0000010;  7: enc = 7'b1111000;  8: enc = 7'b0000000;
      9: enc = 7'b0010000;  DS: enc = 7'b0111111;
      Z: enc = LZB ? 7'b1111111 : 7'b1000000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] i3(input int a, input int b, input int c);
    i3 = {enc(a), enc(b), enc(c)};
  endfunction
  function automatic logic [20:0] i2(input int a, input int b);
    i2 = {7'b0, enc(a), enc(b)};
  endfunction
  function automatic logic [13:0] f2(input int a, input int b);
    f2 = {enc(a), enc(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (if0.done) begin
      dn0++;
      if (q0.size() == 0) check("unexpected_done0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        last0 = e;
        check("latency0", cyc, e.dc);
        check("busy_at_done0", 32'(if0.busy), 32'd0);
        check("overflow0", 32'(if0.overflow), 32'(e.ovf));
        check("seg_sign0", 32'(if0.seg_sign), 32'(e.sg));
        check("seg_int0", 32'(if0.seg_int), 32'(e.si));
        check("seg_frac0", 32'(if0.seg_frac), 32'(e.sf));
      end
    end
    if (if1.done) begin
      dn1++;
      if (q1.size() == 0) check("unexpected_done1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        last1 = e;
        check("latency1", cyc, e.dc);
        check("overflow1", 32'(if1.overflow), 32'(e.ovf));
        check("seg_sign1", 32'(if1.seg_sign), 32'(e.sg));
        check("seg_int1", 32'(if1.seg_int), 32'(e.si));
        check("seg_frac1", 32'(if1.seg_frac), 32'(e.sf));
      end
    end
  end

  // Called just before an active edge; that edge samples start.
  task automatic issue(input int sel, input logic [15:0] d, input logic ov, input logic sn,
                       input logic [20:0] si, input logic [13:0] sf);
    exp_t e;
    e.ovf = ov;
    e.sg  = sn ? 7'b0111111 : 7'b1111111;
    e.si  = si;
    e.sf  = sf;
    e.dc  = cyc + 1 + LAT;
    if (sel == 0) begin
      if0.start = 1'b1; if0.data_in = d; q0.push_back(e);
    end else begin
      if1.start = 1'b1; if1.data_in = d; q1.push_back(e);
    end
    @(posedge clk); #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    check("busy_after_start", 32'(sel == 0 ? if0.busy : if1.busy), 32'd1);
  endtask

  task automatic drain(input int sel);
    for (int t = 0; t < 60 && (q0.size() + q1.size()) != 0; t++) @(posedge clk);
    check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    if (sel == 0) check("hold_int0", 32'(if0.seg_int), 32'(last0.si));
    else          check("hold_frac1", 32'(if1.seg_frac), 32'(last1.sf));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(if0.busy), 32'd0);
    check({tag, "_done"}, 32'(if0.done), 32'd0);
    check({tag, "_ovf"}, 32'(if0.overflow), 32'd0);
    check({tag, "_sign"}, 32'(if0.seg_sign), 32'h7F);
    check({tag, "_int"}, 32'(if0.seg_int), 32'h1FFFFF);
    check({tag, "_frac"}, 32'(if0.seg_frac), 32'h3FFF);
  endtask

  initial begin
    int d0;
    if0.start = 1'b0; if0.data_in = '0;
    if1.start = 1'b0; if1.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single conversions on the 3-digit instance.
    issue(0, 16'h0AA0, 0, 0, i3(Z, 4, 2), f2(5, 0)); drain(0);   // 42.50
    issue(0, 16'hFF60, 0, 1, i3(Z, Z, 2), f2(5, 0)); drain(0);   // -2.50
    issue(0, 16'h0001, 0, 0, i3(Z, Z, 0), f2(0, 1)); drain(0);   // 0.015625 -> 0.01
    issue(0, 16'h8000, 0, 1, i3(5, 1, 2), f2(0, 0)); drain(0);   // -512.00
    issue(0, 16'h7FFF, 0, 0, i3(5, 1, 1), f2(9, 8)); drain(0);   // 511.984 -> 511.98
    issue(0, 16'hFFFF, 0, 1, i3(Z, Z, 0), f2(0, 1)); drain(0);   // -0.015625 -> -0.01
    issue(0, 16'h1A40, 0, 0, i3(1, 0, 5), f2(0, 0)); drain(0);   // 105: inner zero shown
    issue(0, 16'h0A00, 0, 0, i3(Z, 4, 0), f2(0, 0)); drain(0);   // 40: units zero shown

    // Two-digit instance: overflow boundary at 99/100.
    issue(1, 16'h8000, 1, 1, i2(DS, DS), f2(0, 0)); drain(1);    // -512 overflows
    issue(1, 16'h18C0, 0, 0, i2(9, 9), f2(0, 0)); drain(1);      // 99.00
    issue(1, 16'h1900, 1, 0, i2(DS, DS), f2(0, 0)); drain(1);    // 100.00 overflows
    issue(1, 16'h0040, 0, 0, i2(Z, 1), f2(0, 0)); drain(1);      // 1.00

    // Second start three cycles in is ignored; exactly one done follows.
    d0 = dn0;
    issue(0, 16'h0AA0, 0, 0, i3(Z, 4, 2), f2(5, 0));
    repeat (2) @(posedge clk);
    #1;
    if0.start = 1'b1; if0.data_in = 16'h0040;
    @(posedge clk); #1;
    if0.start = 1'b0;
    check("busy_ignored_start", 32'(if0.busy), 32'd1);
    drain(0);
    repeat (20) @(posedge clk);
    check("single_done", 32'(dn0 - d0), 32'd1);

    // Back-to-back: start presented on the done cycle.
    issue(0, 16'h0AA0, 0, 0, i3(Z, 4, 2), f2(5, 0));
    for (int t = 0; t < 40 && !if0.done; t++) @(negedge clk);
    check("done_seen", 32'(if0.done), 32'd1);
    issue(0, 16'h0040, 0, 0, i3(Z, Z, 1), f2(0, 0));
    drain(0);

    // Reset mid-conversion aborts with no done pulse.
    d0 = dn0;
    if0.start = 1'b1; if0.data_in = 16'h7FFF;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_reset("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", 32'(dn0 - d0), 32'd0);
    check("abort_idle", 32'(if0.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
